// File: rtl/spi_slave_shifter_if.sv
// Local-side byte handshake of the SPI target engine.
//   tx_data/tx_valid : next byte to send, offered by local logic
//   tx_ready         : one-cycle pulse, tx_data consumed this cycle
//   tx_underrun      : one-cycle pulse, a load found tx_valid low
//   rx_data/rx_valid : last received byte and its one-cycle update strobe
// Modports: master = local logic, slave = the shifter engine.
interface spi_slave_shifter_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_underrun;
    logic [7:0] rx_data;
    logic       rx_valid;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, tx_underrun, rx_data, rx_valid
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, tx_underrun, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_slave_shifter.sv
// SPI target-side shift engine, all four CPOL/CPHA modes, MSB first, 8-bit frames.
// sck, cs_n and mosi are oversampled in the clk domain; edges are detected on the
// synchronized copies, so sck high/low times must each span several clk periods.
// Ports:
//   clk, rst        : system clock, asynchronous active-low reset
//   cpol, cpha      : SPI mode, static while cs_n is low
//   sck, cs_n, mosi : external SPI inputs (asynchronous)
//   miso, miso_oe   : serial data out and its pad output-enable
//   lb              : local byte handshake (tx valid/ready, rx strobe, underrun)
module spi_slave_shifter #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpol,
    input  logic                 cpha,
    input  logic                 sck,
    input  logic                 cs_n,
    input  logic                 mosi,
    output logic                 miso,
    output logic                 miso_oe,
    spi_slave_shifter_if.slave   lb
);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
    logic                   sck_d, cs_d;
    logic                   sck_s, cs_s, mosi_s;

    logic [0:0] state;
    logic [7:0] tx_sh, rx_sh;
    logic [2:0] bit_cnt;
    logic       skip;       // cpha=1: next leading edge must not shift
    logic [7:0] rx_data_q;
    logic       rx_valid_q;

    // Synchronizers; sck resets to its idle level so no edge is seen at release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sck_sync  <= {SYNC_STAGES{cpol}};
            cs_sync   <= '1;
            mosi_sync <= '0;
            sck_d     <= cpol;
            cs_d      <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sck_d     <= sck_sync[SYNC_STAGES-1];
            cs_d      <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    logic sck_edge, lead_edge, trail_edge, sample_edge, shift_edge;
    logic active, cs_fall, cs_rise, enter, run;
    logic do_sample, last_bit, ld_cpha0, ld_cpha1, load, do_shift;

    assign sck_edge    = sck_s ^ sck_d;
    assign lead_edge   = sck_edge & (sck_d == cpol);
    assign trail_edge  = sck_edge & (sck_d != cpol);
    assign sample_edge = cpha ? trail_edge : lead_edge;
    assign shift_edge  = cpha ? lead_edge : trail_edge;

    assign active  = (state == ACTIVE);
    assign cs_fall = cs_d & ~cs_s;
    assign cs_rise = ~cs_d & cs_s;
    assign enter   = ~active & cs_fall;
    // Deselect wins over any sck edge seen in the same cycle.
    assign run     = active & ~cs_rise;

    assign do_sample = run & sample_edge;
    assign last_bit  = (bit_cnt == 3'd7);
    // cpha=0: a trailing edge with bit_cnt wrapped to 0 can only follow the 8th sample.
    assign ld_cpha0  = ~cpha & run & shift_edge & (bit_cnt == 3'd0);
    assign ld_cpha1  = cpha & do_sample & last_bit;
    assign load      = enter | ld_cpha0 | ld_cpha1;
    assign do_shift  = run & shift_edge & ~ld_cpha0 & ~(cpha & skip);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            tx_sh      <= '0;
            rx_sh      <= '0;
            bit_cnt    <= '0;
            skip       <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;

            if (enter) begin
                state <= ACTIVE;
            end else if (active && cs_rise) begin
                // Partial byte is dropped; the next select reloads from scratch.
                state   <= IDLE;
                bit_cnt <= '0;
                tx_sh   <= '0;
                skip    <= 1'b0;
            end

            if (run && shift_edge && cpha) skip <= 1'b0;

            if (load) begin
                tx_sh <= lb.tx_valid ? lb.tx_data : 8'h00;
                skip  <= 1'b1;
            end else if (do_shift) begin
                tx_sh <= {tx_sh[6:0], 1'b0};
            end

            if (do_sample) begin
                rx_sh   <= {rx_sh[6:0], mosi_s};
                bit_cnt <= bit_cnt + 3'd1;
                if (last_bit) begin
                    rx_data_q  <= {rx_sh[6:0], mosi_s};
                    rx_valid_q <= 1'b1;
                end
            end
        end
    end

    assign miso           = active & tx_sh[7];
    assign miso_oe        = active;
    assign lb.tx_ready    = load & lb.tx_valid;
    assign lb.tx_underrun = load & ~lb.tx_valid;
    assign lb.rx_data     = rx_data_q;
    assign lb.rx_valid    = rx_valid_q;
endmodule

// File: tb/tb_spi_slave_shifter.sv
// Bench for spi_slave_shifter: a behavioural SPI master drives sck/cs_n/mosi and
// collects miso; byte-level expectations come from the mode rules (what the master
// sends must arrive on rx, what local logic offers must arrive at the master).
module tb_spi_slave_shifter;
    localparam int H = 6;   // sck half period in clk cycles

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cpol = 1'b0, cpha = 1'b0;
    logic sck = 1'b0, cs_n = 1'b1, mosi = 1'b0;
    logic miso, miso_oe;

    spi_slave_shifter_if lb();

    spi_slave_shifter #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha),
        .sck(sck), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .lb(lb)
    );

    always #5 clk = ~clk;

    int n_err = 0, n_chk = 0;
    int n_txr = 0, n_und = 0, n_rx = 0;
    int tx_idx = 0, txr_base = 0;
    logic [7:0] tx_buf [8];
    logic [7:0] mo_buf [4];
    logic [7:0] mi_buf [4];
    logic [7:0] rx_log [16];

    // Local logic: present tx_buf in order, advancing after each consumption.
    assign lb.tx_data = tx_buf[(tx_idx - txr_base) & 7];

    always @(negedge clk) begin
        if (lb.tx_ready)    n_txr++;
        if (lb.tx_underrun) n_und++;
        if (lb.rx_valid) begin
            rx_log[n_rx & 15] = lb.rx_data;
            n_rx++;
        end
    end

    always @(posedge clk) tx_idx <= n_txr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_mode(input logic p, input logic h);
        cpol = p; cpha = h; sck = p;
        repeat (6) @(negedge clk);
    endtask

    // Master: nbits bit-periods over mo_buf; a full mode-0 frame ends with cs_n
    // rising together with the final trailing edge. hold leaves cs_n asserted.
    task automatic spi_xfer(input int nbytes, input int nbits, input bit hold);
        bit last;
        for (int b = 0; b < 4; b++) mi_buf[b] = 8'h00;
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            last = (i == nbits - 1) && (nbits == nbytes * 8) && !hold;
            if (!cpha) begin
                mosi = mo_buf[i / 8][7 - (i % 8)];
                repeat (H) @(negedge clk);
                mi_buf[i / 8][7 - (i % 8)] = miso;
                sck = ~cpol;
                repeat (H) @(negedge clk);
                sck = cpol;
                if (last) cs_n = 1'b1;
            end else begin
                sck = ~cpol;
                mosi = mo_buf[i / 8][7 - (i % 8)];
                repeat (H) @(negedge clk);
                mi_buf[i / 8][7 - (i % 8)] = miso;
                sck = cpol;
                repeat (H) @(negedge clk);
            end
        end
        if (!hold) begin
            repeat (H) @(negedge clk);
            cs_n = 1'b1;
            repeat (8) @(negedge clk);
        end
    endtask

    // Full frame of nbytes and scoreboard against the byte-level rules.
    task automatic run_case(input string tag, input int nbytes, input logic valid);
        int txr0, und0, rx0, loads;
        txr0 = n_txr; und0 = n_und; rx0 = n_rx;
        txr_base = n_txr;
        lb.tx_valid = valid;
        spi_xfer(nbytes, nbytes * 8, 1'b0);
        // A load at select plus one per byte boundary; cpha=1 also loads after the last byte.
        loads = cpha ? nbytes + 1 : nbytes;
        chk({tag, " rx count"}, n_rx - rx0, nbytes);
        for (int b = 0; b < nbytes; b++) begin
            chk({tag, " rx byte"}, rx_log[(rx0 + b) & 15], mo_buf[b]);
            chk({tag, " miso byte"}, mi_buf[b], valid ? tx_buf[b] : 8'h00);
        end
        chk({tag, " tx_ready count"}, n_txr - txr0, valid ? loads : 0);
        chk({tag, " underrun count"}, n_und - und0, valid ? 0 : loads);
    endtask

    initial begin
        int txr0, rx0;
        lb.tx_valid = 1'b0;
        for (int i = 0; i < 8; i++) tx_buf[i] = 8'h00;
        for (int i = 0; i < 16; i++) rx_log[i] = 8'h00;

        // Power-on reset values
        repeat (3) @(negedge clk);
        chk("reset miso", miso, 1'b0);
        chk("reset miso_oe", miso_oe, 1'b0);
        chk("reset rx_data", lb.rx_data, 8'h00);
        chk("reset rx_valid", lb.rx_valid, 1'b0);
        chk("reset tx_ready", lb.tx_ready, 1'b0);
        chk("reset underrun", lb.tx_underrun, 1'b0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Mode 0 single byte
        set_mode(1'b0, 1'b0);
        tx_buf[0] = 8'h3C; mo_buf[0] = 8'hA5;
        run_case("mode0", 1, 1'b1);

        // Mode 3, two bytes under one select
        set_mode(1'b1, 1'b1);
        tx_buf[0] = 8'h81; tx_buf[1] = 8'h7E; tx_buf[2] = 8'h55;
        mo_buf[0] = 8'h12; mo_buf[1] = 8'h34;
        run_case("mode3", 2, 1'b1);

        // Modes 1 and 2
        set_mode(1'b0, 1'b1);
        tx_buf[0] = 8'h0F; tx_buf[1] = 8'h0F; mo_buf[0] = 8'hF0;
        run_case("mode1", 1, 1'b1);
        set_mode(1'b1, 1'b0);
        run_case("mode2", 1, 1'b1);

        // Underrun in mode 0
        set_mode(1'b0, 1'b0);
        tx_buf[0] = 8'hFF; mo_buf[0] = 8'h6B;
        run_case("underrun", 1, 1'b0);

        // Abort after 5 bits, then a fresh full byte
        tx_buf[0] = 8'h5A; mo_buf[0] = 8'hFF;
        lb.tx_valid = 1'b1;
        txr0 = n_txr; rx0 = n_rx; txr_base = n_txr;
        spi_xfer(1, 5, 1'b0);
        chk("abort rx count", n_rx - rx0, 0);
        chk("abort tx_ready count", n_txr - txr0, 1);
        tx_buf[0] = 8'h96; mo_buf[0] = 8'hC3;
        run_case("after abort", 1, 1'b1);

        // Reset mid-byte after 3 bits
        tx_buf[0] = 8'hE7; mo_buf[0] = 8'h3A;
        txr_base = n_txr;
        spi_xfer(1, 3, 1'b1);
        chk("pre-reset miso_oe", miso_oe, 1'b1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midreset miso", miso, 1'b0);
        chk("midreset miso_oe", miso_oe, 1'b0);
        chk("midreset rx_data", lb.rx_data, 8'h00);
        chk("midreset rx_valid", lb.rx_valid, 1'b0);
        chk("midreset tx_ready", lb.tx_ready, 1'b0);
        chk("midreset underrun", lb.tx_underrun, 1'b0);
        cs_n = 1'b1; sck = cpol;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        tx_buf[0] = 8'h24; mo_buf[0] = 8'hB1;
        run_case("after reset", 1, 1'b1);

        // Randomized frames
        for (int it = 0; it < 8; it++) begin
            int nb;
            logic m_pol, m_pha, v;
            m_pol = 1'($urandom_range(0, 1));
            m_pha = 1'($urandom_range(0, 1));
            nb = $urandom_range(1, 3);
            v = ($urandom_range(0, 3) != 0);
            for (int b = 0; b < 4; b++) begin
                tx_buf[b] = 8'($urandom);
                mo_buf[b] = 8'($urandom);
            end
            set_mode(m_pol, m_pha);
            run_case("random", nb, v);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
